// File: rtl/completion_bus_arbiter_if.sv
// Completion broadcast bus bundle: requester side (results offered into
// one-entry holding slots) plus the registered broadcast output.
//
// Handshake: a result on slot i transfers on a rising edge where
// reqValid_i[i] and reqReady_o[i] are both 1. reqReady_o may depend
// combinationally on flush_i and the current arbitration winner. Requesters
// must hold their payload stable while reqValid_i[i] is 1 and reqReady_o[i]
// is 0. The broadcast side has no back-pressure: robWriteEn_o qualifies
// tag/value for exactly one cycle per result.
interface completion_bus_arbiter_if #(
  parameter int NUM_REQ    = 5,
  parameter int ROBsizeLog = 5
);
  logic [NUM_REQ-1:0]                 reqValid_i;
  logic [NUM_REQ-1:0][ROBsizeLog-1:0] reqTag_i;
  logic [NUM_REQ-1:0][64:0]           reqVal_i;
  logic [NUM_REQ-1:0]                 reqReady_o;
  logic                               flush_i;
  logic [ROBsizeLog-1:0]              completionRSROBTag_o;
  logic [64:0]                        completionRSROBval_o;
  logic                               robWriteEn_o;
  logic [NUM_REQ-1:0]                 grant_o;

  // Requester / completion-stage side.
  modport master (
    output reqValid_i, reqTag_i, reqVal_i, flush_i,
    input  reqReady_o, completionRSROBTag_o, completionRSROBval_o,
           robWriteEn_o, grant_o
  );

  // Arbiter side.
  modport slave (
    input  reqValid_i, reqTag_i, reqVal_i, flush_i,
    output reqReady_o, completionRSROBTag_o, completionRSROBval_o,
           robWriteEn_o, grant_o
  );
endinterface

// File: rtl/completion_bus_arbiter.sv
// Completion bus arbiter: one holding slot per requester (RS/FU 0..3, LSQ),
// round-robin selection among held slots, registered broadcast output.
// Optional macro CDB_LSQ_PRIORITY_EN: the LSQ slot (NUM_REQ-1) wins whenever
// held and does not move the round-robin pointer.
// Debug outputs expose the round-robin pointer and held-slot mask.
module completion_bus_arbiter #(
  parameter  int NUM_REQ    = 5,
  parameter  int ROBsize    = 16,
  parameter  int ROBsizeLog = $clog2(ROBsize + 1),
  localparam int PTRW       = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  completion_bus_arbiter_if.slave   bus,
  output logic [PTRW-1:0]           o_dbg_rr_ptr,
  output logic [NUM_REQ-1:0]        o_dbg_held
);

  logic [NUM_REQ-1:0]                 r_held;
  logic [NUM_REQ-1:0][ROBsizeLog-1:0] r_tag;
  logic [NUM_REQ-1:0][64:0]           r_val;
  logic [PTRW-1:0]                    r_rr_ptr;
  logic                               r_out_en;
  logic [ROBsizeLog-1:0]              r_out_tag;
  logic [64:0]                        r_out_val;
  logic [NUM_REQ-1:0]                 r_grant;

  logic [NUM_REQ-1:0] w_win;
  logic [PTRW-1:0]    w_win_idx;
  logic               w_any;
  logic               w_lsq_win;
  logic [NUM_REQ-1:0] w_scan_mask;
  logic [NUM_REQ-1:0] w_ready;
  logic [NUM_REQ-1:0] w_capture;

  // Pick the first held slot starting at the round-robin pointer.
  always_comb begin
    int idx;
    idx         = 0;
    w_win       = '0;
    w_win_idx   = '0;
    w_any       = 1'b0;
    w_lsq_win   = 1'b0;
    w_scan_mask = r_held;
`ifdef CDB_LSQ_PRIORITY_EN
    w_scan_mask[NUM_REQ-1] = 1'b0;
    if (r_held[NUM_REQ-1]) begin
      w_win[NUM_REQ-1] = 1'b1;
      w_win_idx        = PTRW'(NUM_REQ - 1);
      w_any            = 1'b1;
      w_lsq_win        = 1'b1;
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_any && w_scan_mask[idx]) begin
        w_win[idx] = 1'b1;
        w_win_idx  = PTRW'(idx);
        w_any      = 1'b1;
      end
    end
  end

  // A slot can take a new result when empty or when its entry leaves this edge;
  // tag 0 results are accepted but not stored.
  always_comb begin
    w_ready   = {NUM_REQ{~bus.flush_i}} & (~r_held | w_win);
    w_capture = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_capture[i] = bus.reqValid_i[i] & w_ready[i] & (|bus.reqTag_i[i]);
    end
  end

  // Held-slot flags, round-robin pointer and broadcast register.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_held    <= '0;
      r_rr_ptr  <= '0;
      r_out_en  <= 1'b0;
      r_out_tag <= '0;
      r_out_val <= '0;
      r_grant   <= '0;
    end else if (bus.flush_i) begin
      r_held   <= '0;
      r_out_en <= 1'b0;
      r_grant  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_capture[i])  r_held[i] <= 1'b1;
        else if (w_win[i]) r_held[i] <= 1'b0;
      end
      r_out_en <= w_any;
      r_grant  <= w_win;
      if (w_any) begin
        r_out_tag <= r_tag[w_win_idx];
        r_out_val <= r_val[w_win_idx];
        if (!w_lsq_win) begin
          r_rr_ptr <= (w_win_idx == PTRW'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
        end
      end
    end
  end

  // Slot payload capture; data needs no reset because r_held qualifies it.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_capture[i]) begin
        r_tag[i] <= bus.reqTag_i[i];
        r_val[i] <= bus.reqVal_i[i];
      end
    end
  end

  assign bus.reqReady_o           = w_ready;
  assign bus.robWriteEn_o         = r_out_en;
  assign bus.completionRSROBTag_o = r_out_tag;
  assign bus.completionRSROBval_o = r_out_val;
  assign bus.grant_o              = r_grant;
  assign o_dbg_rr_ptr             = r_rr_ptr;
  assign o_dbg_held               = r_held;

endmodule

// File: tb/tb_completion_bus_arbiter.sv
// Bench for completion_bus_arbiter: per-cycle vector table plus hand-written
// sequences (fixed-value broadcast, LSQ priority when CDB_LSQ_PRIORITY_EN).
module tb_completion_bus_arbiter;

  localparam int N  = 5;
  localparam int TW = 5;

  logic          clk_i;
  logic          reset_i;
  logic [2:0]    dbg_rr_ptr;
  logic [N-1:0]  dbg_held;
  int            n_checks;
  int            n_fail;

  completion_bus_arbiter_if #(.NUM_REQ(N), .ROBsizeLog(TW)) bus ();

  completion_bus_arbiter #(.NUM_REQ(N), .ROBsize(16)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .bus          (bus),
    .o_dbg_rr_ptr (dbg_rr_ptr),
    .o_dbg_held   (dbg_held)
  );

  // Clock / reset block
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    bit                 rst_n;
    bit                 flush;
    logic [N-1:0]       vld;
    logic [N*TW-1:0]    tags;
    logic [N-1:0]       exp_rdy;
    bit                 exp_en;
    logic [N-1:0]       exp_grant;
    logic [TW-1:0]      exp_tag;
    logic [2:0]         exp_rr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst_n, bit flush, logic [N-1:0] vld,
                              logic [N*TW-1:0] tags, logic [N-1:0] rdy, bit en,
                              logic [N-1:0] grant, logic [TW-1:0] tag, logic [2:0] rr);
    vec_t v;
    v.rst_n = rst_n; v.flush = flush; v.vld = vld; v.tags = tags;
    v.exp_rdy = rdy; v.exp_en = en; v.exp_grant = grant; v.exp_tag = tag; v.exp_rr = rr;
    return v;
  endfunction

  // Payload pattern for a given slot/tag; bit 64 follows tag bit 0.
  function automatic logic [64:0] val_of(int slot, logic [TW-1:0] tag);
    return {tag[0], 8'hA5, 40'h0, 8'(slot), 8'(tag)};
  endfunction

  // Scoreboard compare
  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input bit rst_n, input bit flush, input logic [N-1:0] vld,
                       input logic [N*TW-1:0] tags);
    reset_i     = rst_n;
    bus.flush_i = flush;
    for (int i = 0; i < N; i++) begin
      bus.reqValid_i[i] = vld[i];
      bus.reqTag_i[i]   = tags[i*TW +: TW];
      bus.reqVal_i[i]   = val_of(i, tags[i*TW +: TW]);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_out(input string name, input bit en, input logic [N-1:0] grant,
                           input logic [TW-1:0] tag, input logic [64:0] val, input logic [2:0] rr);
    check({name, " en"}, 65'(bus.robWriteEn_o), 65'(en));
    check({name, " grant"}, 65'(bus.grant_o), 65'(grant));
    check({name, " rr"}, 65'(dbg_rr_ptr), 65'(rr));
    if (en) begin
      check({name, " tag"}, 65'(bus.completionRSROBTag_o), 65'(tag));
      check({name, " val"}, bus.completionRSROBval_o, val);
    end
  endtask

  function automatic int onehot_idx(logic [N-1:0] g);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  localparam logic [N*TW-1:0] NT = '0;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drive(1'b0, 1'b0, '0, NT);
    step();

`ifdef CDB_LSQ_PRIORITY_EN
    // LSQ and FU1 held with rrPtr=1: LSQ broadcasts first, pointer stays.
    drive(1'b1, 1'b0, 5'b00001, {5'd0, 5'd0, 5'd0, 5'd0, 5'd1});
    step();
    check_out("prio c1", 1'b0, '0, '0, '0, 3'd0);
    drive(1'b1, 1'b0, '0, NT);
    step();
    check_out("prio c2", 1'b1, 5'b00001, 5'd1, val_of(0, 5'd1), 3'd1);
    drive(1'b1, 1'b0, 5'b10010, {5'd3, 5'd0, 5'd0, 5'd2, 5'd0});
    step();
    check_out("prio c3", 1'b0, '0, '0, '0, 3'd1);
    drive(1'b1, 1'b0, '0, NT);
    step();
    check_out("prio c4", 1'b1, 5'b10000, 5'd3, val_of(4, 5'd3), 3'd1);
    step();
    check_out("prio c5", 1'b1, 5'b00010, 5'd2, val_of(1, 5'd2), 3'd2);
    step();
    check_out("prio c6", 1'b0, '0, '0, '0, 3'd2);
`else
    // Vector table: inputs for one cycle, ready before the edge, outputs after.
    vecs.push_back(mk(0,0,5'b00000, NT,                                5'b11111, 0,5'b00000, 5'd0,3'd0));
    vecs.push_back(mk(1,0,5'b00001, {5'd0,5'd0,5'd0,5'd0,5'd3},        5'b11111, 0,5'b00000, 5'd0,3'd0));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b11111, 1,5'b00001, 5'd3,3'd1));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b11111, 0,5'b00000, 5'd0,3'd1));
    vecs.push_back(mk(0,0,5'b00000, NT,                                5'b11111, 0,5'b00000, 5'd0,3'd0));
    vecs.push_back(mk(1,0,5'b11111, {5'd5,5'd4,5'd3,5'd2,5'd1},        5'b11111, 0,5'b00000, 5'd0,3'd0));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b00001, 1,5'b00001, 5'd1,3'd1));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b00011, 1,5'b00010, 5'd2,3'd2));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b00111, 1,5'b00100, 5'd3,3'd3));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b01111, 1,5'b01000, 5'd4,3'd4));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b11111, 1,5'b10000, 5'd5,3'd0));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b11111, 0,5'b00000, 5'd0,3'd0));
    vecs.push_back(mk(1,0,5'b00100, {5'd0,5'd0,5'd1,5'd0,5'd0},        5'b11111, 0,5'b00000, 5'd0,3'd0));
    for (int k = 2; k <= 8; k++)
      vecs.push_back(mk(1,0,5'b00100, {5'd0,5'd0,5'(k),5'd0,5'd0},     5'b11111, 1,5'b00100, 5'(k-1),3'd3));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b11111, 1,5'b00100, 5'd8,3'd3));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b11111, 0,5'b00000, 5'd0,3'd3));
    vecs.push_back(mk(1,0,5'b01011, {5'd0,5'd9,5'd0,5'd7,5'd6},        5'b11111, 0,5'b00000, 5'd0,3'd3));
    vecs.push_back(mk(1,1,5'b00000, NT,                                5'b00000, 0,5'b00000, 5'd0,3'd3));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b11111, 0,5'b00000, 5'd0,3'd3));
    vecs.push_back(mk(1,1,5'b00001, {5'd0,5'd0,5'd0,5'd0,5'd5},        5'b00000, 0,5'b00000, 5'd0,3'd3));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b11111, 0,5'b00000, 5'd0,3'd3));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b11111, 0,5'b00000, 5'd0,3'd3));
    vecs.push_back(mk(1,0,5'b01111, {5'd0,5'd4,5'd3,5'd2,5'd1},        5'b11111, 0,5'b00000, 5'd0,3'd3));
    vecs.push_back(mk(0,0,5'b00000, NT,                                5'b11000, 0,5'b00000, 5'd0,3'd0));
    vecs.push_back(mk(1,0,5'b10011, {5'd14,5'd0,5'd0,5'd13,5'd12},     5'b11111, 0,5'b00000, 5'd0,3'd0));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b01101, 1,5'b00001, 5'd12,3'd1));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b01111, 1,5'b00010, 5'd13,3'd2));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b11111, 1,5'b10000, 5'd14,3'd0));
    vecs.push_back(mk(1,0,5'b00010, NT,                                5'b11111, 0,5'b00000, 5'd0,3'd0));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b11111, 0,5'b00000, 5'd0,3'd0));
    vecs.push_back(mk(1,0,5'b00000, NT,                                5'b11111, 0,5'b00000, 5'd0,3'd0));

    foreach (vecs[r]) begin
      drive(vecs[r].rst_n, vecs[r].flush, vecs[r].vld, vecs[r].tags);
      #1;
      check($sformatf("row%0d ready", r), 65'(bus.reqReady_o), 65'(vecs[r].exp_rdy));
      step();
      check_out($sformatf("row%0d", r), vecs[r].exp_en, vecs[r].exp_grant, vecs[r].exp_tag,
                val_of(onehot_idx(vecs[r].exp_grant), vecs[r].exp_tag), vecs[r].exp_rr);
    end
`endif

    // Fixed-value result from FU0: broadcast two cycles after acceptance.
    drive(1'b0, 1'b0, '0, NT);
    step();
    check_out("t1 reset", 1'b0, '0, '0, '0, 3'd0);
    check("t1 reset tag", 65'(bus.completionRSROBTag_o), 65'd0);
    check("t1 reset val", bus.completionRSROBval_o, 65'd0);
    check("t1 reset held", 65'(dbg_held), 65'd0);
    drive(1'b1, 1'b0, 5'b00001, {5'd0, 5'd0, 5'd0, 5'd0, 5'd3});
    bus.reqVal_i[0] = 65'h1234;
    step();
    drive(1'b1, 1'b0, '0, NT);
    check_out("t1 t+1", 1'b0, '0, '0, '0, 3'd0);
    step();
    check_out("t1 t+2", 1'b1, 5'b00001, 5'd3, 65'h1234, 3'd1);
    step();
    check_out("t1 t+3", 1'b0, '0, '0, '0, 3'd1);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
